latch_bank_write_sched: RTL and testbench

//  Schedules write access from NREQ requesters onto a shared bank of DEPTH mux-based D latches, each WIDTH bits wide.

---
 rtl/latch_bank_write_sched_pkg.sv | 21 ++
 rtl/latch_bank_write_sched_if.sv | 33 +++
 rtl/latch_bank_write_sched_rr_arbiter.sv | 30 +++
 rtl/latch_bank_write_sched.sv | 124 ++++++++++++
 tb/tb_latch_bank_write_sched.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/latch_bank_write_sched_pkg.sv
// Shared definitions for the latch-bank write scheduler.
//  - state_t : write-sequence FSM encoding (3 bits)
//  - clog2   : counter/pointer width helper, never returns less than 1
package latch_bank_write_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ENABLE = 3'd2,
    HOLD   = 3'd3,
    ACK    = 3'd4
  } state_t;

  function automatic int clog2(input int v);
    int w;
    w = 1;
    while ((1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/latch_bank_write_sched_if.sv
// Bus between the requesters and the scheduler, plus the latch-bank drive.
//  master : requester side (drives req/wr_addr/wr_data, observes the rest)
//  slave  : scheduler side
//  req      NREQ        level write request per requester
//  wr_addr  NREQ*AW     requester i address at [i*AW +: AW]
//  wr_data  NREQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
//  grant    NREQ        one-hot current owner
//  ack      NREQ        one-cycle completion pulse
//  err      1           out-of-range address, pulses with ack
//  busy     1           scheduler not idle
//  latch_d  WIDTH       shared latch data bus
//  latch_en DEPTH       one-hot latch enables
interface latch_bank_write_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    wr_addr;
  logic [NREQ*WIDTH-1:0] wr_data;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       ack;
  logic                  err;
  logic                  busy;
  logic [WIDTH-1:0]      latch_d;
  logic [DEPTH-1:0]      latch_en;

  modport master (output req, wr_addr, wr_data,
                  input  grant, ack, err, busy, latch_d, latch_en);
  modport slave  (input  req, wr_addr, wr_data,
                  output grant, ack, err, busy, latch_d, latch_en);
endinterface

// File: rtl/latch_bank_write_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//  req : request vector
//  ptr : highest-priority index; search wraps from ptr upward
//  win : one-hot winner, zero when no request
module rr_arbiter
  import latch_bank_write_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]        req,
  input  logic [clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]        win
);
  int   idx;
  logic found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/latch_bank_write_sched.sv
// Write scheduler for a bank of DEPTH level-sensitive latches.
// Arbitrates NREQ requesters round-robin and runs each write through
// IDLE -> SETUP -> ENABLE(xEN_CYC) -> HOLD -> ACK. Every output is a flop,
// so latch_en cannot glitch; latch_d only moves on the grant edge and
// latch_en only moves on later edges, so transparency never sees a data edge.
//  clock/reset : rising-edge clock, async active-high reset
//  bus         : slave side of latch_bank_write_sched_if
module latch_bank_write_sched
  import latch_bank_write_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = 2,
  parameter int EN_CYC = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  latch_bank_write_sched_if.slave bus
);
  localparam int PW = clog2(NREQ);
  localparam int CW = clog2(EN_CYC);

  state_t            state, state_n;
  logic [NREQ-1:0]   grant_q, grant_n, ack_q, ack_n, win;
  logic [AW-1:0]     addr_q, addr_n;
  logic [WIDTH-1:0]  d_q, d_n;
  logic [DEPTH-1:0]  en_q, en_n, dec;
  logic              err_q, err_n, busy_q, busy_n, oob;
  logic [PW-1:0]     ptr, ptr_n, win_idx;
  logic [CW-1:0]     cnt, cnt_n;

  rr_arbiter #(.NREQ(NREQ)) u_arb (.req(bus.req), .ptr(ptr), .win(win));

  // one-hot winner back to an index for operand select and pointer update
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (win[i]) win_idx = PW'(i);
  end

  // decode from the captured address; out-of-range leaves every enable low
  always_comb begin
    for (int d = 0; d < DEPTH; d++) dec[d] = (addr_q == AW'(d));
  end
  assign oob = int'(addr_q) >= DEPTH;

  always_comb begin
    state_n = state;
    grant_n = grant_q;
    addr_n  = addr_q;
    d_n     = d_q;
    ptr_n   = ptr;
    cnt_n   = cnt;
    en_n    = '0;
    ack_n   = '0;
    err_n   = 1'b0;
    case (state)
      IDLE: if (|bus.req) begin
        state_n = SETUP;
        grant_n = win;
        addr_n  = bus.wr_addr[win_idx*AW +: AW];
        d_n     = bus.wr_data[win_idx*WIDTH +: WIDTH];
        ptr_n   = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
      end
      SETUP: begin
        state_n = ENABLE;
        cnt_n   = '0;
        en_n    = dec;
      end
      ENABLE: begin
        if (cnt == CW'(EN_CYC-1)) state_n = HOLD;
        else begin
          cnt_n = cnt + 1'b1;
          en_n  = dec;
        end
      end
      HOLD: begin
        state_n = ACK;
        ack_n   = grant_q;
        err_n   = oob;
      end
      ACK: begin
        state_n = IDLE;
        grant_n = '0;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      d_q     <= '0;
      ptr     <= '0;
      cnt     <= '0;
      en_q    <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      grant_q <= grant_n;
      addr_q  <= addr_n;
      d_q     <= d_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      en_q    <= en_n;
      ack_q   <= ack_n;
      err_q   <= err_n;
      busy_q  <= busy_n;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.latch_d  = d_q;
  assign bus.latch_en = en_q;
endmodule

// File: tb/tb_latch_bank_write_sched.sv
// Directed bench: dut0 (AW=3, EN_CYC=1) covers arbitration, out-of-range,
// input changes after grant and reset mid-write; dut1 (AW=2, EN_CYC=3)
// covers the long enable. A monitor flags any enable change landing in the
// same cycle as a data change on either instance.
module tb_latch_bank_write_sched;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  latch_bank_write_sched_if #(.NREQ(4), .WIDTH(8), .DEPTH(4), .AW(3)) if0();
  latch_bank_write_sched_if #(.NREQ(4), .WIDTH(8), .DEPTH(4), .AW(2)) if1();

  latch_bank_write_sched #(.NREQ(4), .WIDTH(8), .DEPTH(4), .AW(3), .EN_CYC(1))
    dut0 (.clock(clock), .reset(reset), .bus(if0));
  latch_bank_write_sched #(.NREQ(4), .WIDTH(8), .DEPTH(4), .AW(2), .EN_CYC(3))
    dut1 (.clock(clock), .reset(reset), .bus(if1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    if0.req = '0;
    if1.req = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // data/enable overlap monitor, sampled mid-cycle
  logic [3:0] pen0, pen1;
  logic [7:0] pd0, pd1;
  logic       prst = 1'b1;
  always @(negedge clock) begin
    if (!reset && !prst) begin
      if (if0.latch_en !== pen0) chk("overlap0", 32'(if0.latch_d !== pd0), 32'd0);
      if (if1.latch_en !== pen1) chk("overlap1", 32'(if1.latch_d !== pd1), 32'd0);
    end
    pen0 = if0.latch_en; pd0 = if0.latch_d;
    pen1 = if1.latch_en; pd1 = if1.latch_d;
    prst = reset;
  end

  logic [3:0] g;

  initial begin
    if0.req = '0; if0.wr_addr = '0; if0.wr_data = '0;
    if1.req = '0; if1.wr_addr = '0; if1.wr_data = '0;
    #2;
    do_reset();

    // reset state
    chk("rst_grant", if0.grant, 4'b0000);
    chk("rst_ack", if0.ack, 4'b0000);
    chk("rst_err", if0.err, 1'b0);
    chk("rst_busy", if0.busy, 1'b0);
    chk("rst_en", if0.latch_en, 4'b0000);
    chk("rst_d", if0.latch_d, 8'h00);

    // 1: single write, addr 2
    if0.wr_addr[0 +: 3] = 3'd2;
    if0.wr_data[0 +: 8] = 8'hA5;
    if0.req = 4'b0001;
    step(); chk("t1_grant", if0.grant, 4'b0001); chk("t1_d", if0.latch_d, 8'hA5);
    chk("t1_busy", if0.busy, 1'b1); chk("t1_en_setup", if0.latch_en, 4'b0000);
    step(); chk("t1_en", if0.latch_en, 4'b0100);
    step(); chk("t1_en_hold", if0.latch_en, 4'b0000); chk("t1_ack_early", if0.ack, 4'b0000);
    step(); chk("t1_ack", if0.ack, 4'b0001); chk("t1_err", if0.err, 1'b0);
    if0.req = '0;
    step(); chk("t1_idle_busy", if0.busy, 1'b0); chk("t1_idle_grant", if0.grant, 4'b0000);
    chk("t1_ack_pulse", if0.ack, 4'b0000); chk("t1_d_held", if0.latch_d, 8'hA5);

    // 2: all requesting, rotation from pointer 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if0.wr_addr[i*3 +: 3] = 3'(i);
      if0.wr_data[i*8 +: 8] = 8'(8'h10 + i);
    end
    if0.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      g = 4'b0001 << (n % 4);
      step(); chk("t2_grant", if0.grant, g); chk("t2_d", if0.latch_d, 8'h10 + (n % 4));
      step(); chk("t2_en", if0.latch_en, g);
      step();
      step(); chk("t2_ack", if0.ack, g); chk("t2_err", if0.err, 1'b0);
      step(); chk("t2_gap", if0.grant, 4'b0000);
    end
    if0.req = '0;

    // 3: out-of-range address from requester 1
    do_reset();
    if0.wr_addr[3 +: 3] = 3'b111;
    if0.req = 4'b0010;
    step(); chk("t3_grant", if0.grant, 4'b0010);
    step(); chk("t3_en_a", if0.latch_en, 4'b0000);
    step(); chk("t3_en_b", if0.latch_en, 4'b0000);
    step(); chk("t3_ack", if0.ack, 4'b0010); chk("t3_err", if0.err, 1'b1);
    if0.req = '0;
    step(); chk("t3_err_pulse", if0.err, 1'b0);

    // 4: data change and req drop during ENABLE
    do_reset();
    if0.wr_addr[0 +: 3] = 3'd1;
    if0.wr_data[0 +: 8] = 8'h3C;
    if0.req = 4'b0001;
    step(); chk("t4_d", if0.latch_d, 8'h3C);
    step(); chk("t4_en", if0.latch_en, 4'b0010);
    if0.wr_data[0 +: 8] = 8'hFF;
    if0.req = '0;
    step(); chk("t4_d_hold", if0.latch_d, 8'h3C);
    step(); chk("t4_ack", if0.ack, 4'b0001); chk("t4_d_ack", if0.latch_d, 8'h3C);
    step(); chk("t4_idle", if0.busy, 1'b0);
    step(); chk("t4_no_regrant", if0.grant, 4'b0000);

    // 5: reset during ENABLE, pointer restart
    do_reset();
    if0.wr_addr[0 +: 3] = 3'd0;
    if0.wr_data[0 +: 8] = 8'h11;
    if0.req = 4'b0001;
    step();
    step(); chk("t5_en", if0.latch_en, 4'b0001);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_en", if0.latch_en, 4'b0000);
    chk("t5_rst_grant", if0.grant, 4'b0000);
    chk("t5_rst_busy", if0.busy, 1'b0);
    if0.req = '0;
    step();
    reset = 1'b0;
    chk("t5_idle", if0.busy, 1'b0);
    if0.wr_addr[3 +: 3] = 3'd3;
    if0.req = 4'b0011;
    step(); chk("t5_ptr0", if0.grant, 4'b0001);
    step(); step();
    step(); chk("t5_ack", if0.ack, 4'b0001);
    if0.req = '0;
    step();

    // 6: EN_CYC=3 on dut1
    do_reset();
    if1.wr_addr[0 +: 2] = 2'd3;
    if1.wr_data[0 +: 8] = 8'h5A;
    if1.req = 4'b0001;
    step(); chk("t6_grant", if1.grant, 4'b0001); chk("t6_d", if1.latch_d, 8'h5A);
    chk("t6_en_setup", if1.latch_en, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      step(); chk("t6_en", if1.latch_en, 4'b1000);
    end
    step(); chk("t6_en_off", if1.latch_en, 4'b0000); chk("t6_d_hold", if1.latch_d, 8'h5A);
    step(); chk("t6_ack", if1.ack, 4'b0001); chk("t6_err", if1.err, 1'b0);
    if1.req = '0;
    step(); chk("t6_idle", if1.busy, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
